// File: rtl/multicycle_processor.sv
// ---------------------------------------------------------------------------
// multicycle_processor
//
// Multi-cycle compute core. Each instruction runs through FETCH, EXEC and WB,
// so it takes exactly three clocks. The program lives in an internal RAM. That
// RAM is loaded through the imem_* port while the core is IDLE or HALTED.
//
// Instruction word layout, with the opcode in the MSBs:
//   [op 3][rd REG_AW][rs REG_AW][imm DATA_W]
//
//   op   mnemonic  effect
//   000  ADDI      R[rd] = R[rd] + imm
//   001  ADD       R[rd] = R[rd] + R[rs]
//   010  SUB       R[rd] = R[rd] - R[rs]
//   011  LI        R[rd] = imm
//   100  BNZ       if R[rd] != 0 then pc += sext(imm), else pc += 1; rVal = R[rd]
//   101  AND       R[rd] = R[rd] & R[rs]
//   110  NOP       nothing changes except pc
//   111  HALT      pc holds, the instruction is counted, then the core enters HALTED
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears all state except the imem contents
//   start       one-cycle pulse; begins execution at pc=0 (accepted only in IDLE/HALTED)
//   imem_we     program-load write strobe (accepted only in IDLE/HALTED)
//   imem_addr   program-load address
//   imem_wdata  program-load word
//   running     1 while in FETCH/EXEC/WB
//   halted      1 while in HALTED
//   pc          current program counter
//   instr       instruction register (last fetched word)
//   rVal        last ALU result, latched in EXEC
//   retired     instructions completed since start; saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module multicycle_processor #(
   parameter  int DATA_W     = 8,
   parameter  int NREG       = 8,
   parameter  int IMEM_DEPTH = 32,
   localparam int REG_AW     = $clog2(NREG),
   localparam int PC_W       = $clog2(IMEM_DEPTH),
   localparam int INSTR_W    = 3 + 2*REG_AW + DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               imem_we,
   input  logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_wdata,
   output logic               running,
   output logic               halted,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr,
   output logic [DATA_W-1:0]  rVal,
   output logic [15:0]        retired
);

   // Width wide enough to sign-extend the immediate before it is truncated
   // to PC_W. This matters when the immediate is narrower than the pc.
   localparam int EXT_W = (PC_W > DATA_W) ? PC_W : DATA_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WB,
      S_HALTED
   } state_t;

   typedef enum logic [2:0] {
      OP_ADDI = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_LI   = 3'b011,
      OP_BNZ  = 3'b100,
      OP_AND  = 3'b101,
      OP_NOP  = 3'b110,
      OP_HALT = 3'b111
   } op_t;

   state_t state, state_nxt;

   // Control strobes produced by the output process
   logic idle_like;   // IDLE or HALTED: start and program load are accepted
   logic do_start;
   logic ld_instr;
   logic do_exec;
   logic do_wb;

   // Decoded fields of the instruction register
   op_t               op;
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rs;
   logic [DATA_W-1:0] imm;

   logic [DATA_W-1:0] regs [NREG];
   logic [INSTR_W-1:0] imem [IMEM_DEPTH];

   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] exec_val;
   logic [PC_W-1:0]   next_pc;
   logic              reg_we;

   assign op     = op_t'(instr[INSTR_W-1 -: 3]);
   assign rd     = instr[DATA_W+REG_AW +: REG_AW];
   assign rs     = instr[DATA_W +: REG_AW];
   assign imm    = instr[DATA_W-1:0];
   assign rd_val = regs[rd];
   assign rs_val = regs[rs];

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: state elements use non-blocking (<=) assignments. Every flop then
   // samples its pre-edge inputs, regardless of the order of the processes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_EXEC;
         S_EXEC:   state_nxt = S_WB;
         S_WB:     state_nxt = (op == OP_HALT) ? S_HALTED : S_FETCH;
         S_HALTED: if (start) state_nxt = S_FETCH;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output / strobe decode
   // -------------------------------------------------------------------------
   // NOTE: every output of a combinational block gets a default first. That
   // way, no path through the case statement can leave a signal unassigned and
   // infer a latch.
   always_comb begin
      running   = 1'b0;
      halted    = 1'b0;
      idle_like = 1'b0;
      ld_instr  = 1'b0;
      do_exec   = 1'b0;
      do_wb     = 1'b0;
      unique case (state)
         S_IDLE:   idle_like = 1'b1;
         S_FETCH:  begin running = 1'b1; ld_instr = 1'b1; end
         S_EXEC:   begin running = 1'b1; do_exec  = 1'b1; end
         S_WB:     begin running = 1'b1; do_wb    = 1'b1; end
         S_HALTED: begin halted  = 1'b1; idle_like = 1'b1; end
         default:  ;
      endcase
   end

   assign do_start = start & idle_like;

   // -------------------------------------------------------------------------
   // Execute: ALU result, latched into rVal during EXEC.
   // BNZ exposes the tested register. NOP and HALT leave rVal untouched.
   // -------------------------------------------------------------------------
   always_comb begin
      exec_val = rVal;
      unique case (op)
         OP_ADDI: exec_val = rd_val + imm;
         OP_ADD:  exec_val = rd_val + rs_val;
         OP_SUB:  exec_val = rd_val - rs_val;
         OP_LI:   exec_val = imm;
         OP_AND:  exec_val = rd_val & rs_val;
         OP_BNZ:  exec_val = rd_val;
         default: exec_val = rVal;
      endcase
   end

   // -------------------------------------------------------------------------
   // Write-back: next pc and register write enable.
   // For BNZ, rVal holds R[rd] from EXEC, so the branch decision uses rVal.
   // pc arithmetic is PC_W wide, so both pc+1 and the branch target wrap
   // modulo IMEM_DEPTH without extra logic.
   // -------------------------------------------------------------------------
   always_comb begin
      next_pc = pc + PC_W'(1);
      if (op == OP_HALT)
         next_pc = pc;
      else if (op == OP_BNZ && rVal != '0)
         next_pc = pc + PC_W'(EXT_W'($signed(imm)));
   end

   assign reg_we = do_wb & ((op == OP_ADDI) | (op == OP_ADD) | (op == OP_SUB) |
                            (op == OP_LI)   | (op == OP_AND));

   // -------------------------------------------------------------------------
   // Program RAM
   // -------------------------------------------------------------------------
   // NOTE: the instruction memory has no reset on purpose. Reset must keep the
   // loaded program, and leaving a RAM out of reset lets it map to a memory
   // macro or block RAM.
   always_ff @(posedge clk) begin
      if (imem_we && idle_like) imem[imem_addr] <= imem_wdata;
   end

   // -------------------------------------------------------------------------
   // Register file (cleared by reset, written only in WB)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (reg_we) begin
         regs[rd] <= rVal;
      end
   end

   // -------------------------------------------------------------------------
   // pc, instruction register, result register, retired counter
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= '0;
         instr   <= '0;
         rVal    <= '0;
         retired <= '0;
      end else begin
         if (do_start) begin
            pc      <= '0;
            retired <= '0;
         end
         if (ld_instr) instr <= imem[pc];
         if (do_exec)  rVal  <= exec_val;
         if (do_wb) begin
            pc <= next_pc;
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_processor.sv
// ---------------------------------------------------------------------------
// tb_multicycle_processor
//
// Directed programs with hand-computed results. Before each run, the stimulus
// pushes the expected post-WB snapshot of every instruction into a queue.
// The snapshot is (rVal, pc, retired, halted, cycles since start). A monitor
// detects each retirement by watching retired step up by one, then pops the
// queue and compares.
// ---------------------------------------------------------------------------
module tb_multicycle_processor;

   localparam int DATA_W     = 8;
   localparam int NREG       = 8;
   localparam int IMEM_DEPTH = 32;
   localparam int PC_W       = 5;
   localparam int INSTR_W    = 17;

   localparam logic [2:0] ADDI = 3'b000, ADD = 3'b001, SUB = 3'b010, LI = 3'b011,
                          BNZ  = 3'b100, AND = 3'b101, NOP = 3'b110, HALT = 3'b111;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               imem_we;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_wdata;
   logic               running;
   logic               halted;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;
   logic [DATA_W-1:0]  rVal;
   logic [15:0]        retired;

   multicycle_processor #(
      .DATA_W     (DATA_W),
      .NREG       (NREG),
      .IMEM_DEPTH (IMEM_DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .running    (running),
      .halted     (halted),
      .pc         (pc),
      .instr      (instr),
      .rVal       (rVal),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  rval;
      logic [4:0]  pc;
      logic [15:0] ret;
      logic        halted;
      int          dcyc;
   } exp_t;

   exp_t sb_q[$];

   int tests_run    = 0;
   int tests_failed = 0;
   int cycle        = 0;
   int start_cycle  = 0;
   logic [15:0] prev_ret;

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [INSTR_W-1:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                               input logic [2:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   // Expected snapshot after the WB of the n-th instruction. That WB
   // completes 3*n clocks after the start edge.
   task automatic push(input logic [7:0] rval, input logic [4:0] epc,
                       input logic [15:0] ret, input logic hlt);
      exp_t e;
      e.rval = rval; e.pc = epc; e.ret = ret; e.halted = hlt; e.dcyc = 3 * int'(ret);
      sb_q.push_back(e);
   endtask

   // Monitor: a retirement shows up as retired increasing by exactly one
   always @(negedge clk) begin
      if (!reset && retired == prev_ret + 16'd1) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_retire", 32'(sb_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rval",    32'(rVal),    32'(e.rval));
            check("pc",      32'(pc),      32'(e.pc));
            check("retired", 32'(retired), 32'(e.ret));
            check("halted",  32'(halted),  32'(e.halted));
            check("wb_cycle", 32'(cycle - start_cycle), 32'(e.dcyc));
         end
      end
      prev_ret = retired;
   end

   task automatic load(input logic [4:0] addr, input logic [INSTR_W-1:0] word);
      @(negedge clk);
      imem_we = 1'b1; imem_addr = addr; imem_wdata = word;
      @(negedge clk);
      imem_we = 1'b0;
   endtask

   // real_start=1 re-bases the cycle reference for the wb_cycle comparison.
   // A start pulse that should be ignored leaves the reference alone.
   task automatic pulse_start(input bit real_start);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (real_start) start_cycle = cycle;
   endtask

   task automatic wait_halt(input int max_cyc);
      int n = 0;
      while (!halted && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("halt_reached", 32'(halted), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_running", 32'(running), 32'd0);
      check("rst_halted",  32'(halted),  32'd0);
      check("rst_pc",      32'(pc),      32'd0);
      check("rst_instr",   32'(instr),   32'd0);
      check("rst_rval",    32'(rVal),    32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      reset = 1'b0;

      // 1: LI R1,5; ADDI R1,3; HALT
      load(0, enc(LI,   1, 0, 8'd5));
      load(1, enc(ADDI, 1, 0, 8'd3));
      load(2, enc(HALT, 0, 0, 8'd0));
      push(8'd5, 5'd1, 16'd1, 1'b0);
      push(8'd8, 5'd2, 16'd2, 1'b0);
      push(8'd8, 5'd2, 16'd3, 1'b1);
      pulse_start(1);
      check("t1_running", 32'(running), 32'd1);
      wait_halt(40);

      // 2: countdown loop. LI R2,3 / ADDI R2,-1 / BNZ R2,-1 / HALT.
      // Retired total: LI + 3*ADDI + 3*BNZ + HALT = 8.
      load(0, enc(LI,   2, 0, 8'd3));
      load(1, enc(ADDI, 2, 0, 8'hFF));
      load(2, enc(BNZ,  2, 0, 8'hFF));
      load(3, enc(HALT, 0, 0, 8'd0));
      push(8'd3, 5'd1, 16'd1, 1'b0);
      push(8'd2, 5'd2, 16'd2, 1'b0);
      push(8'd2, 5'd1, 16'd3, 1'b0);
      push(8'd1, 5'd2, 16'd4, 1'b0);
      push(8'd1, 5'd1, 16'd5, 1'b0);
      push(8'd0, 5'd2, 16'd6, 1'b0);
      push(8'd0, 5'd3, 16'd7, 1'b0);
      push(8'd0, 5'd3, 16'd8, 1'b1);
      pulse_start(1);
      check("t2_restart_retired", 32'(retired), 32'd0);
      wait_halt(80);

      // 3: wrap-around arithmetic, and rd==rs
      load(0, enc(LI,   1, 0, 8'hF0));
      load(1, enc(LI,   2, 0, 8'h20));
      load(2, enc(ADD,  1, 2, 8'd0));
      load(3, enc(SUB,  2, 1, 8'd0));
      load(4, enc(AND,  1, 2, 8'd0));
      load(5, enc(SUB,  1, 1, 8'd0));
      load(6, enc(HALT, 0, 0, 8'd0));
      push(8'hF0, 5'd1, 16'd1, 1'b0);
      push(8'h20, 5'd2, 16'd2, 1'b0);
      push(8'h10, 5'd3, 16'd3, 1'b0);
      push(8'h10, 5'd4, 16'd4, 1'b0);
      push(8'h10, 5'd5, 16'd5, 1'b0);
      push(8'h00, 5'd6, 16'd6, 1'b0);
      push(8'h00, 5'd6, 16'd7, 1'b1);
      pulse_start(1);
      wait_halt(60);

      // 4: branch target wraps (0 + -4 -> 28) and pc wraps (31 -> 0).
      // R2 = 0x10 is left over from test 3.
      load(0,  enc(BNZ,  2, 0, 8'hFC));
      load(1,  enc(HALT, 0, 0, 8'd0));
      load(28, enc(SUB,  2, 2, 8'd0));
      load(29, enc(LI,   6, 0, 8'h5A));
      load(30, enc(NOP,  0, 0, 8'd0));
      load(31, enc(NOP,  0, 0, 8'd0));
      push(8'h10, 5'd28, 16'd1, 1'b0);
      push(8'h00, 5'd29, 16'd2, 1'b0);
      push(8'h5A, 5'd30, 16'd3, 1'b0);
      push(8'h5A, 5'd31, 16'd4, 1'b0);
      push(8'h5A, 5'd0,  16'd5, 1'b0);
      push(8'h00, 5'd1,  16'd6, 1'b0);
      push(8'h00, 5'd1,  16'd7, 1'b1);
      pulse_start(1);
      wait_halt(60);

      // 5: reset during EXEC of ADD R1,R6 (R6 = 0x5A before the reset)
      load(0, enc(LI,   1, 0, 8'd7));
      load(1, enc(ADD,  1, 6, 8'd0));
      load(2, enc(HALT, 0, 0, 8'd0));
      push(8'd7, 5'd1, 16'd1, 1'b0);
      pulse_start(1);
      while (cycle < start_cycle + 4) @(posedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
      check("t5_running", 32'(running), 32'd0);
      check("t5_halted",  32'(halted),  32'd0);
      check("t5_pc",      32'(pc),      32'd0);
      check("t5_rval",    32'(rVal),    32'd0);
      check("t5_retired", 32'(retired), 32'd0);
      check("t5_sb",      32'(sb_q.size()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      // The program survives the reset. R6 is now 0, so ADD gives 7, not 0x61.
      push(8'd7, 5'd1, 16'd1, 1'b0);
      push(8'd7, 5'd2, 16'd2, 1'b0);
      push(8'd7, 5'd2, 16'd3, 1'b1);
      pulse_start(1);
      wait_halt(40);

      // 6: imem write and start pulse while running must both be ignored
      push(8'd7, 5'd1, 16'd1, 1'b0);
      push(8'd7, 5'd2, 16'd2, 1'b0);
      push(8'd7, 5'd2, 16'd3, 1'b1);
      pulse_start(1);
      imem_we = 1'b1; imem_addr = 5'd2; imem_wdata = enc(LI, 3, 0, 8'h33);
      @(posedge clk);
      #1;
      imem_we = 1'b0;
      pulse_start(0);
      check("t6_running", 32'(running), 32'd1);
      wait_halt(40);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
